// File: rtl/mux16_1_16b.sv
// Purpose : registered 16:1 multiplexer of 16-bit words onto a single datapath bus.
// Latency : 1 cycle (RES reflects sel/data sampled at the previous rising clk edge).
// Backpressure: none; pure datapath, a new selection is accepted every cycle.
//
// Ports:
//   clk                 system clock, RES updates on rising edge
//   rst_n               asynchronous active-low reset, clears RES to 16'h0000
//   A..P   [15:0]       data inputs, A = index 0 ... P = index 15
//   sel3..sel0          select index s = {sel3, sel2, sel1, sel0}
//   en                  load enable (only when MUX16_HOLD_EN is defined)
//   RES    [15:0]       registered selected word
//
// Optional feature macro: MUX16_HOLD_EN adds the en port; RES holds when en = 0.
module mux16_1_16b (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [15:0] C,
  input  logic [15:0] D,
  input  logic [15:0] E,
  input  logic [15:0] F,
  input  logic [15:0] G,
  input  logic [15:0] H,
  input  logic [15:0] I,
  input  logic [15:0] J,
  input  logic [15:0] K,
  input  logic [15:0] L,
  input  logic [15:0] M,
  input  logic [15:0] N,
  input  logic [15:0] O,
  input  logic [15:0] P,
  input  logic        sel3,
  input  logic        sel2,
  input  logic        sel1,
  input  logic        sel0,
`ifdef MUX16_HOLD_EN
  input  logic        en,
`endif
  output logic [15:0] RES
);

  // Sources gathered in index order so the tree can be written as loops.
  logic [15:0] src  [16];
  // Intermediate stages of the 2:1 tree: 8, 4, 2 and 1 mux outputs.
  logic [15:0] lvl1 [8];
  logic [15:0] lvl2 [4];
  logic [15:0] lvl3 [2];
  logic [15:0] mux_d;
  logic        load;

  assign src[0]  = A;
  assign src[1]  = B;
  assign src[2]  = C;
  assign src[3]  = D;
  assign src[4]  = E;
  assign src[5]  = F;
  assign src[6]  = G;
  assign src[7]  = H;
  assign src[8]  = I;
  assign src[9]  = J;
  assign src[10] = K;
  assign src[11] = L;
  assign src[12] = M;
  assign src[13] = N;
  assign src[14] = O;
  assign src[15] = P;

  // Level 1: sel0 picks between adjacent pairs (even index when 0).
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      lvl1[i] = sel0 ? src[2*i+1] : src[2*i];
    end
  end

  // Level 2: sel1 picks between adjacent level-1 results.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lvl2[i] = sel1 ? lvl1[2*i+1] : lvl1[2*i];
    end
  end

  // Level 3: sel2 picks between adjacent level-2 results.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      lvl3[i] = sel2 ? lvl2[2*i+1] : lvl2[2*i];
    end
  end

  // Level 4: sel3 chooses the lower (A..H) or upper (I..P) half.
  assign mux_d = sel3 ? lvl3[1] : lvl3[0];

`ifdef MUX16_HOLD_EN
  assign load = en;
`else
  assign load = 1'b1;
`endif

  // Output register; reset takes priority over the load enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RES <= 16'h0000;
    end else if (load) begin
      RES <= mux_d;
    end
  end

endmodule

// File: tb/tb_mux16_1_16b.sv
`timescale 1ns/1ps
module tb_mux16_1_16b;

  logic        clk;
  logic        clk_on;
  logic        rst_n;
  logic [15:0] A, B, C, D, E, F, G, H, I, J, K, L, M, N, O, P;
  logic        sel3, sel2, sel1, sel0;
`ifdef MUX16_HOLD_EN
  logic        en;
`endif
  logic [15:0] RES;

  int checks;
  int failures;

  typedef struct {
    logic [3:0]  s;
    logic [15:0] exp;
  } vec_t;

  vec_t sweep [16];

  mux16_1_16b dut (
    .clk(clk), .rst_n(rst_n),
    .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G), .H(H),
    .I(I), .J(J), .K(K), .L(L), .M(M), .N(N), .O(O), .P(P),
    .sel3(sel3), .sel2(sel2), .sel1(sel1), .sel0(sel0),
`ifdef MUX16_HOLD_EN
    .en(en),
`endif
    .RES(RES)
  );

  // 10 ns clock, held low until clk_on is raised.
  initial clk = 1'b0;
  always #5 clk = clk_on ? ~clk : 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic set_sel(input logic [3:0] s);
    {sel3, sel2, sel1, sel0} = s;
  endtask

  initial begin
    longint t0;
    checks   = 0;
    failures = 0;
    clk_on   = 1'b0;
    rst_n    = 1'b1;
`ifdef MUX16_HOLD_EN
    en       = 1'b1;
`endif

    sweep[0]  = '{4'd0,  16'h0001};
    sweep[1]  = '{4'd1,  16'h0002};
    sweep[2]  = '{4'd2,  16'h0004};
    sweep[3]  = '{4'd3,  16'h0008};
    sweep[4]  = '{4'd4,  16'h0010};
    sweep[5]  = '{4'd5,  16'h0020};
    sweep[6]  = '{4'd6,  16'h0040};
    sweep[7]  = '{4'd7,  16'h0080};
    sweep[8]  = '{4'd8,  16'h0100};
    sweep[9]  = '{4'd9,  16'h0200};
    sweep[10] = '{4'd10, 16'h0400};
    sweep[11] = '{4'd11, 16'h0800};
    sweep[12] = '{4'd12, 16'h1000};
    sweep[13] = '{4'd13, 16'h2000};
    sweep[14] = '{4'd14, 16'h4000};
    sweep[15] = '{4'd15, 16'h8000};

    // Reset with arbitrary data and no clock running.
    A = 16'h1234; B = 16'hBEEF; C = 16'h0F0F; D = 16'hFFFF;
    E = 16'h5555; F = 16'hAAAA; G = 16'h7777; H = 16'h0101;
    I = 16'h2222; J = 16'h3333; K = 16'h4444; L = 16'h6666;
    M = 16'h8888; N = 16'h9999; O = 16'hCCCC; P = 16'hDDDD;
    set_sel(4'd6);
    #2 rst_n = 1'b0;
    #2 check("reset_no_clock", RES, 16'h0000);

    // One-hot inputs: input i = 1 << i.
    A = 16'h0001; B = 16'h0002; C = 16'h0004; D = 16'h0008;
    E = 16'h0010; F = 16'h0020; G = 16'h0040; H = 16'h0080;
    I = 16'h0100; J = 16'h0200; K = 16'h0400; L = 16'h0800;
    M = 16'h1000; N = 16'h2000; O = 16'h4000; P = 16'h8000;
    set_sel(4'd0);
    clk_on = 1'b1;
    @(posedge clk); #1;
    check("reset_held_with_clock", RES, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("release_before_edge", RES, 16'h0000);
    @(posedge clk); #1;
    check("release_first_edge", RES, 16'h0001);

    // One-hot sweep, each selection held for 28 ns.
    @(negedge clk);
    for (int v = 0; v < 16; v++) begin
      t0 = $time;
      set_sel(sweep[v].s);
      @(posedge clk); #1;
      check($sformatf("sweep_s%0d", v), RES, sweep[v].exp);
      if ($time < t0 + 28) #(t0 + 28 - $time);
    end

    // Mid-cycle select glitch between edges.
    @(negedge clk);
    set_sel(4'd3);
    @(posedge clk); #1;
    check("glitch_setup", RES, 16'h0008);
    @(negedge clk);
    set_sel(4'd12);
    #1 check("glitch_during_pulse", RES, 16'h0008);
    #1 set_sel(4'd3);
    @(posedge clk); #1;
    check("glitch_after_edge", RES, 16'h0008);

    // Data follow on P with s = 15.
    @(negedge clk);
    set_sel(4'd15);
    @(posedge clk); #1;
    check("follow_setup", RES, 16'h8000);
    @(negedge clk);
    P = 16'hA5A5;
    #1 check("follow_not_before_edge", RES, 16'h8000);
    @(posedge clk); #1;
    check("follow_after_edge", RES, 16'hA5A5);

    // Simultaneous sel and data change take effect together.
    @(negedge clk);
    set_sel(4'd5);
    F = 16'h3C3C;
    @(posedge clk); #1;
    check("sel_and_data_same_cycle", RES, 16'h3C3C);

    // Reset mid-run.
    @(negedge clk);
    set_sel(4'd10);
    @(posedge clk); #1;
    check("midreset_setup", RES, 16'h0400);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check("midreset_immediate", RES, 16'h0000);
    @(posedge clk); #1;
    check("midreset_held", RES, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midreset_release", RES, 16'h0400);

`ifdef MUX16_HOLD_EN
    @(negedge clk);
    set_sel(4'd2);
    en = 1'b1;
    @(posedge clk); #1;
    check("en_load", RES, 16'h0004);
    @(negedge clk);
    en = 1'b0;
    set_sel(4'd7);
    @(posedge clk); #1;
    check("en_hold_1", RES, 16'h0004);
    @(posedge clk); #1;
    check("en_hold_2", RES, 16'h0004);
    @(negedge clk);
    en = 1'b1;
    @(posedge clk); #1;
    check("en_reload", RES, 16'h0080);
    @(negedge clk);
    en = 1'b0;
    #1 rst_n = 1'b0;
    #1 check("en_reset_override", RES, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
`endif

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case something stalls the main sequence.
  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mux16_1_16b.md
# mux16_1_16b

Registered 16-to-1 multiplexer for 16-bit words, used in the 4-bit CPU datapath to pick one of sixteen 16-bit sources (register file outputs, ALU results, constants) onto a single bus. Four discrete select bits choose the source. The selected word is captured into an output register on every rising clock edge. The module is a pure datapath block: no handshake and no internal state beyond the output register.

## Interface
Parameters
- None. Width (16) and input count (16) are fixed.

Ports
- clk  in  1  system clock; RES updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- A … P  in  16 each  data inputs; A = index 0, B = 1, … P = 15
- sel3  in  1  select bit 3 (MSB)
- sel2  in  1  select bit 2
- sel1  in  1  select bit 1
- sel0  in  1  select bit 0 (LSB)
- en  in  1  load enable; present only when MUX16_HOLD_EN is defined
- RES  out  16  registered selected word

## Operation
- Select index s = {sel3, sel2, sel1, sel0}, range 0–15.
- s selects the input in alphabetical order: 0→A, 1→B, … 15→P.
  - Example: s = 4'b1010 selects K.
- Selection logic is a 4-level tree of 2:1 muxes, replicated per bit:
  - level 1 switches on sel0 (8 muxes);
  - level 2 on sel1 (4 muxes);
  - level 3 on sel2 (2 muxes);
  - level 4 on sel3 (1 mux).
- All 16 select codes are valid. There is no error or default case.
- The combinational tree output (mux_d) is internal only. RES is taken solely from the register.
- Bits are independent. No bit reordering, sign handling or arithmetic.
- Unknown (X) on any select bit is a verification error. The design does not define an output value for it.

## Timing
- Reset:
  - rst_n low forces RES = 16'h0000 immediately, with no clock needed.
  - RES stays 16'h0000 for as long as rst_n is low.
- Release: the first rising clk edge with rst_n high loads mux_d.
- Latency is 1 cycle. RES after edge k equals the input selected by the sel bits and data sampled at edge k.
- Changes to sel or data between edges have no effect on RES until the next rising edge.
- A sel change and a data change in the same cycle: both take effect together at the next edge.
- Reset asserted mid-operation clears RES asynchronously. The last-loaded value is lost.
- Throughput: a new selection every cycle.
- Minimum hold of a selection is 1 cycle. Stimulus holding each selection for 28 ns with a clock of 14 ns or less sees every value.

## Configuration
- Macro: MUX16_HOLD_EN.
- Defined:
  - Port en exists.
  - At each rising edge, RES loads mux_d when en = 1 and holds its value when en = 0.
  - Reset overrides en.
- Not defined:
  - Port en is absent.
  - RES loads mux_d on every rising edge.

## Test plan
- Reset: drive rst_n = 0 with arbitrary inputs, no clock → RES = 16'h0000. Release rst_n with A = 16'h0001 and s = 0 → RES = 16'h0001 after the first edge.
- One-hot sweep:
  - Inputs: A = 16'h0001, B = 16'h0002, … P = 16'h8000 (input i = 1 << i).
  - Stimulus: step s from 0 to 15, holding each value 28 ns, with clk period 10 ns.
  - Required response: RES = 1 << s one edge after each change. Every bit position appears exactly once.
- Mid-cycle sel glitch: with s = 3, briefly pulse s to 12 between edges and restore 3 before the next edge → RES stays 16'h0008 throughout.
- Data follow: hold s = 15 and change P from 16'h8000 to 16'hA5A5 → RES = 16'hA5A5 at the next edge, not before.
- Reset mid-run: with RES = 16'h0400 (s = 10), assert rst_n low between edges → RES = 16'h0000 immediately. After release, RES = 16'h0400 at the first edge.
- With MUX16_HOLD_EN:
  - With s = 2, en = 1 → RES = 16'h0004.
  - Set en = 0 and s = 7 → RES stays 16'h0004.
  - Set en = 1 → RES = 16'h0080 at the next edge.
